// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD add/subtract unit: lanes grouped by `width`, per-group carry chains,
// optional signed/unsigned saturation, valid/ready handshake and a sticky overflow bit.
module simd_alu_pipe #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  localparam int DW    = LANES * LANE_W,
  localparam int WW    = $clog2(LANES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [WW-1:0] width,
  input  logic          sub,
  input  logic          signed_mode,
  input  logic          saturate,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] c,
  output logic [LANES-1:0] out_ovf,
  input  logic          clr_sticky,
  output logic          ovf_sticky
);

  logic          s1_valid;
  logic [DW-1:0] s1_a, s1_b;
  logic [WW-1:0] s1_mask;
  logic          s1_sub, s1_signed, s1_sat;

  logic          s2_advance;
  logic [WW-1:0] mask_in;

  logic [DW-1:0]    sum_raw;
  logic [LANES-1:0] cout_l;
  logic [LANES-1:0] ovf_end;
  logic [LANES-1:0] ovf_next;
  logic [DW-1:0]    c_next;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  // Group mask: lane i belongs to the group whose end lane is (i | mask).
  always_comb begin
    mask_in = '1;
    if (int'(width) < WW)
      mask_in = WW'((1 << width) - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_mask   <= '0;
      s1_sub    <= 1'b0;
      s1_signed <= 1'b0;
      s1_sat    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= a;
        s1_b      <= sub ? ~b : b;
        s1_mask   <= mask_in;
        s1_sub    <= sub;
        s1_signed <= signed_mode;
        s1_sat    <= saturate;
      end
    end
  end

  // Raw sums; the carry chain restarts with `sub` at every group's lowest lane.
  always_comb begin
    logic             carry;
    logic [LANE_W:0]  lane_sum;
    carry    = 1'b0;
    lane_sum = '0;
    sum_raw  = '0;
    cout_l   = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((WW'(i) & s1_mask) == '0)
        carry = s1_sub;
      lane_sum = {1'b0, s1_a[i*LANE_W +: LANE_W]} + {1'b0, s1_b[i*LANE_W +: LANE_W]}
               + {{LANE_W{1'b0}}, carry};
      sum_raw[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
      carry     = lane_sum[LANE_W];
      cout_l[i] = carry;
    end
  end

  // Overflow is only meaningful at a group's end lane; it is then broadcast to the group.
  always_comb begin
    int               msb;
    int               e;
    logic             a_neg;
    logic [LANE_W-1:0] sat_v;
    msb      = 0;
    e        = 0;
    a_neg    = 1'b0;
    sat_v    = '0;
    ovf_end  = '0;
    ovf_next = '0;
    c_next   = sum_raw;
    for (int i = 0; i < LANES; i++) begin
      msb = (i + 1) * LANE_W - 1;
      if (s1_signed)
        ovf_end[i] = (s1_a[msb] == s1_b[msb]) && (sum_raw[msb] != s1_a[msb]);
      else
        ovf_end[i] = cout_l[i] ^ s1_sub;
    end
    for (int j = 0; j < LANES; j++) begin
      e           = j | int'(s1_mask);
      ovf_next[j] = ovf_end[e];
      a_neg       = s1_a[(e + 1) * LANE_W - 1];
      if (s1_signed) begin
        if (j == e)
          sat_v = a_neg ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        else
          sat_v = a_neg ? '0 : '1;
      end else begin
        sat_v = s1_sub ? '0 : '1;
      end
      if (s1_sat && ovf_next[j])
        c_next[j*LANE_W +: LANE_W] = sat_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      out_ovf   <= '0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        c       <= c_next;
        out_ovf <= ovf_next;
      end
    end
  end

  // Setting on an overflowing transfer takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && (|out_ovf))
      ovf_sticky <= 1'b1;
    else if (clr_sticky)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe (LANES=4, LANE_W=8): vector table plus hand-written
// backpressure, sticky-priority and mid-operation reset sequences.
module tb_simd_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [1:0]  width;
  logic        sub, signed_mode, saturate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic [3:0]  out_ovf;
  logic        clr_sticky;
  logic        ovf_sticky;

  int checks = 0;
  int failures = 0;

  simd_alu_pipe #(.LANE_W(8), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .width(width), .sub(sub), .signed_mode(signed_mode),
    .saturate(saturate), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .out_ovf(out_ovf), .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  width;
    logic        sub;
    logic        sgn;
    logic        sat;
    logic [31:0] c;
    logic [3:0]  ovf;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Issue one beat with out_ready=1 and check its result two cycles later.
  // clr_at_out raises clr_sticky in the very cycle the result transfers.
  task automatic run_vec(input int k, input logic clr_at_out);
    @(negedge clk);
    in_valid = 1'b1; a = vecs[k].a; b = vecs[k].b; width = vecs[k].width;
    sub = vecs[k].sub; signed_mode = vecs[k].sgn; saturate = vecs[k].sat;
    out_ready = 1'b1;
    #1 chk($sformatf("v%0d in_ready", k), {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk($sformatf("v%0d valid_early", k), {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d out_valid", k), {31'b0, out_valid}, 32'd1);
    chk($sformatf("v%0d c", k), c, vecs[k].c);
    chk($sformatf("v%0d ovf", k), {28'b0, out_ovf}, {28'b0, vecs[k].ovf});
    clr_sticky = clr_at_out;
  endtask

  logic [31:0] bp_a   [4];
  logic [31:0] bp_exp [4];
  logic [31:0] held_c;
  int sent, got;

  initial begin
    vecs[0]  = '{32'h10FF7F80, 32'h01010101, 2'd0, 1'b0, 1'b0, 1'b1, 32'h11FF8081, 4'b0100};
    vecs[1]  = '{32'h7FFF8000, 32'h0001FFFF, 2'd1, 1'b0, 1'b1, 1'b1, 32'h7FFF8000, 4'b1111};
    vecs[2]  = '{32'h7FFF8000, 32'h0001FFFF, 2'd1, 1'b0, 1'b1, 1'b0, 32'h80007FFF, 4'b1111};
    vecs[3]  = '{32'h00000005, 32'h00000007, 2'd2, 1'b1, 1'b0, 1'b1, 32'h00000000, 4'b1111};
    vecs[4]  = '{32'h00000005, 32'h00000007, 2'd2, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b1111};
    vecs[5]  = '{32'h00000005, 32'h00000007, 2'd3, 1'b1, 1'b0, 1'b1, 32'h00000000, 4'b1111};
    vecs[6]  = '{32'h00000005, 32'h00000007, 2'd3, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b1111};
    vecs[7]  = '{32'h807F0005, 32'h01FF0105, 2'd0, 1'b1, 1'b1, 1'b1, 32'h807FFF00, 4'b1100};
    vecs[8]  = '{32'h12345678, 32'h11111111, 2'd2, 1'b0, 1'b0, 1'b1, 32'h23456789, 4'b0000};
    vecs[9]  = '{32'h00050A10, 32'h01020B01, 2'd0, 1'b1, 1'b0, 1'b0, 32'hFF03FF0F, 4'b1010};
    vecs[10] = '{32'h00050A10, 32'h01020B01, 2'd0, 1'b1, 1'b0, 1'b1, 32'h0003000F, 4'b1010};
    vecs[11] = '{32'h7FFFFFFF, 32'h00000001, 2'd3, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 4'b1111};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; width = '0; sub = 1'b0;
    signed_mode = 1'b0; saturate = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    #12;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst c", c, 32'd0);
    chk("rst ovf", {28'b0, out_ovf}, 32'd0);
    chk("rst sticky", {31'b0, ovf_sticky}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++)
      run_vec(k, 1'b0);
    @(negedge clk);
    clr_sticky = 1'b0;
    #1 chk("sticky after ovf", {31'b0, ovf_sticky}, 32'd1);

    // Sticky: clear alone, then set and clear in the same cycle (set wins), then clear alone.
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    #1 chk("sticky clr", {31'b0, ovf_sticky}, 32'd0);
    run_vec(0, 1'b1);
    @(negedge clk);
    #1 chk("sticky set wins", {31'b0, ovf_sticky}, 32'd1);
    @(negedge clk);
    #1 chk("sticky clr alone", {31'b0, ovf_sticky}, 32'd0);
    clr_sticky = 1'b0;

    // Backpressure: 4 distinct beats against a stalled output.
    for (int i = 0; i < 4; i++) begin
      bp_a[i]   = 32'h01000001 * (i + 1);
      bp_exp[i] = bp_a[i] + 32'h00000010;
    end
    sent = 0; got = 0; held_c = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid = (sent < 4);
      a = bp_a[sent % 4]; b = 32'h00000010; width = 2'd2;
      sub = 1'b0; signed_mode = 1'b0; saturate = 1'b1;
      #1;
      if (cyc == 3) held_c = c;
      if (cyc == 5) begin
        chk("bp accepted", sent, 32'd2);
        chk("bp in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp c stable", c, held_c);
        chk("bp c head", c, bp_exp[0]);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp out%0d", got), c, bp_exp[got % 4]);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("bp all out", got, 32'd4);
    chk("bp all in", sent, 32'd4);

    // Reset with two overflowing beats in flight and the sticky bit set.
    run_vec(1, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b; width = 2'd0;
      sub = 1'b0; signed_mode = 1'b0; saturate = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("pre-rst valid", {31'b0, out_valid}, 32'd1);
    chk("pre-rst sticky", {31'b0, ovf_sticky}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid-rst c", c, 32'd0);
    chk("mid-rst ovf", {28'b0, out_ovf}, 32'd0);
    chk("mid-rst sticky", {31'b0, ovf_sticky}, 32'd0);
    chk("mid-rst in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      #1 chk($sformatf("post-rst idle%0d", cyc), {31'b0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
